mem_arbiter: RTL and testbench

- Shares the single backing-memory port between the instruction-side and data-side caches. Each cache issues a read-line or write-word request.
- The arbiter picks one requester and drives the memory strobes for a fixed MEM_LATENCY cycles. It then captures the returned line and pulses done to the winner.
- Sits between the two cache instances and the memory model; memory-side strobes are readM/writeM-style level signals.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_sel.sv | 36 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared states, encodings and default latency for the I/D memory arbiter
package mem_arb_pkg;

    // Strobe hold time used by the arbiter and by the memory model it talks to.
    localparam int MEM_LATENCY_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - combinational winner select; MEM_ARB_RR_EN selects round-robin over fixed D-first
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic   i_read,
    input  logic   d_read,
    input  logic   d_write,
    input  owner_e last_grant,
    output logic   grant_valid,
    output owner_e grant_owner,
    output op_e    grant_op
);

    logic d_req;
    assign d_req = d_read | d_write;

    // D wins by default; under round-robin a tie goes to the side not served last.
    // A D-side write outranks a D-side read so the read simply stays pending.
    always_comb begin
        grant_valid = i_read | d_req;
        grant_owner = d_req ? OWN_D : OWN_I;
`ifdef MEM_ARB_RR_EN
        if (i_read && d_req) begin
            grant_owner = (last_grant == OWN_D) ? OWN_I : OWN_D;
        end
`endif
        grant_op = (grant_owner == OWN_D && d_write) ? OP_WRITE : OP_READ;
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores history; last_grant is still tracked by the top.
    logic last_grant_unused;
    assign last_grant_unused = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between I- and D-cache; MEM_ARB_RR_EN enables round-robin
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 64,
    parameter int WORD_W      = 16
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_done,
    output logic [LINE_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_e            owner_q, owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;

    logic              grant_valid;
    owner_e            grant_owner;
    op_e               grant_op;

    mem_arb_sel u_sel (
        .i_read      (i_read),
        .d_read      (d_read),
        .d_write     (d_write),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner),
        .grant_op    (grant_op)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests are sampled only in IDLE; BUSY ends on the last strobe cycle; DONE is one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = BUSY;
            BUSY:    if (cnt_q == CNT_ONE) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the strobes, frozen request fields, captured line and done pulses.
    always_comb begin
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        rdata_d      = rdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d      = grant_owner;
                    last_grant_d = grant_owner;
                    mem_addr_d   = (grant_owner == OWN_D) ? d_addr : i_addr;
                    if (grant_op == OP_WRITE) begin
                        mem_wdata_d = d_wdata;
                        mem_write_d = 1'b1;
                    end else begin
                        mem_read_d  = 1'b1;
                    end
                    cnt_d = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (cnt_q == CNT_ONE) begin
                    if (mem_read_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_done_d    = (owner_q == OWN_I);
                    d_done_d    = (owner_q == OWN_D);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any transaction without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            owner_q      <= OWN_D;
            last_grant_q <= OWN_I;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            rdata_q      <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            rdata_q      <= rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
        end
    end

    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign rdata     = rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter; honours MEM_ARB_RR_EN
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int L = MEM_LATENCY_DEF;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        i_read    = 1'b0;
    logic [15:0] i_addr    = '0;
    logic        d_read    = 1'b0;
    logic        d_write   = 1'b0;
    logic [15:0] d_addr    = '0;
    logic [15:0] d_wdata   = '0;
    logic [63:0] mem_rdata = '0;
    logic        i_done, d_done, mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata;
    logic [63:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit keep_alive = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(L), .ADDR_W(16), .LINE_W(64), .WORD_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_addr(i_addr), .i_done(i_done),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: line at address a is {q, q-1, q-2, q-3} with q = a >> 4.
    function automatic logic [63:0] line_of(input logic [15:0] a);
        logic [15:0] q;
        q = a >> 4;
        return {q, q - 16'd1, q - 16'd2, q - 16'd3};
    endfunction

    // Transaction-level model: m_t counts edges since the grant edge.
    bit          m_busy    = 1'b0;
    int          m_t       = 0;
    owner_e      m_own     = OWN_D;
    op_e         m_op      = OP_READ;
    owner_e      m_last    = OWN_I;
    logic [15:0] m_addr    = '0;
    logic [15:0] exp_wdata = '0;
    logic [63:0] exp_rdata = '0;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_busy = 1'b0; m_t = 0; m_own = OWN_D; m_op = OP_READ; m_last = OWN_I;
            m_addr = '0; exp_wdata = '0; exp_rdata = '0;
        end else if (m_busy) begin
            m_t++;
            if (m_t == L && m_op == OP_READ) exp_rdata = line_of(m_addr);
            if (m_t == L + 1) m_busy = 1'b0;
        end else if (i_read || d_read || d_write) begin
            bit dq;
            dq = d_read || d_write;
            if (dq && i_read) begin
`ifdef MEM_ARB_RR_EN
                m_own = (m_last == OWN_D) ? OWN_I : OWN_D;
`else
                m_own = OWN_D;
`endif
            end else begin
                m_own = dq ? OWN_D : OWN_I;
            end
            m_op   = (m_own == OWN_D && d_write) ? OP_WRITE : OP_READ;
            m_addr = (m_own == OWN_D) ? d_addr : i_addr;
            if (m_op == OP_WRITE) exp_wdata = d_wdata;
            m_last = m_own;
            m_busy = 1'b1;
            m_t    = 0;
        end
    end

    // Memory returns the line only on the last strobe cycle; noise otherwise.
    initial forever begin
        @(posedge clk);
        #1;
        if (m_busy && m_op == OP_READ && m_t == L - 1) mem_rdata = line_of(m_addr);
        else mem_rdata = {$urandom, $urandom};
    end

    // Per-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            check("mem_read",  64'(mem_read),  64'(m_busy && m_t < L && m_op == OP_READ));
            check("mem_write", 64'(mem_write), 64'(m_busy && m_t < L && m_op == OP_WRITE));
            check("i_done",    64'(i_done),    64'(m_busy && m_t == L && m_own == OWN_I));
            check("d_done",    64'(d_done),    64'(m_busy && m_t == L && m_own == OWN_D));
            check("mem_addr",  64'(mem_addr),  64'(m_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
            check("rdata",     rdata,          exp_rdata);
        end
    end

    // One clock; the requester that was just completed drops its request.
    task automatic tick();
        @(posedge clk);
        #2;
        if (m_busy && m_t == L && !keep_alive) begin
            if (m_own == OWN_I)        i_read  = 1'b0;
            else if (m_op == OP_WRITE) d_write = 1'b0;
            else                       d_read  = 1'b0;
        end
    endtask

    bit          w_rd [64];
    bit          w_wr [64];
    bit          w_id [64];
    bit          w_dd [64];
    logic [15:0] w_ad [64];
    logic [15:0] w_wd [64];
    logic [63:0] w_rdat [64];
    int          w_n = 0;

    task automatic watch(input int n, input int act_k);
        w_n = n;
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == act_k) begin
                d_addr  = 16'h0300;
                d_write = 1'b0;
            end
            @(negedge clk);
            w_rd[k] = mem_read; w_wr[k] = mem_write; w_id[k] = i_done; w_dd[k] = d_done;
            w_ad[k] = mem_addr; w_wd[k] = mem_wdata; w_rdat[k] = rdata;
        end
    endtask

    function automatic int first1(input bit a [64], input int from, input int upto);
        for (int k = from; k < upto; k++) if (a[k]) return k;
        return -1;
    endfunction

    function automatic int count1(input bit a [64], input int upto);
        int c;
        c = 0;
        for (int k = 0; k < upto; k++) if (a[k]) c++;
        return c;
    endfunction

    initial begin
        int seq [4];
        int ns;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_read",  64'(mem_read),  64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_i_done",    64'(i_done),    64'd0);
        check("rst_d_done",    64'(d_done),    64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rdata",     rdata,          64'd0);
        @(posedge clk); #2; reset_n = 1'b1;

        // Single I read
        i_read = 1'b1; i_addr = 16'h0040;
        watch(L + 6, -1);
        check_int("iread_strobe_cycles", count1(w_rd, w_n), L);
        check_int("iread_strobe_first",  first1(w_rd, 0, w_n), 0);
        check("iread_mem_addr", 64'(w_ad[0]), 64'h0040);
        check_int("iread_done_cycle", first1(w_id, 0, w_n), L);
        check_int("iread_done_count", count1(w_id, w_n), 1);
        check("iread_rdata", w_rdat[L], 64'h0004_0003_0002_0001);

        // D write
        d_write = 1'b1; d_addr = 16'h0123; d_wdata = 16'hBEEF;
        watch(L + 6, -1);
        check_int("dwr_strobe_cycles", count1(w_wr, w_n), L);
        check_int("dwr_no_read",       count1(w_rd, w_n), 0);
        check("dwr_mem_wdata", 64'(w_wd[0]), 64'hBEEF);
        check("dwr_mem_addr",  64'(w_ad[0]), 64'h0123);
        check_int("dwr_done_count", count1(w_dd, w_n), 1);
        check("dwr_rdata_kept", w_rdat[L], 64'h0004_0003_0002_0001);

        // Contention once: D first, then I two cycles after D drops its strobe
        i_read = 1'b1; i_addr = 16'h0500; d_read = 1'b1; d_addr = 16'h0600;
        watch(2 * (L + 2) + 4, -1);
        check_int("cont_d_done", first1(w_dd, 0, w_n), L);
        check_int("cont_i_done", first1(w_id, 0, w_n), 2 * L + 2);
        check_int("cont_gap",    first1(w_rd, L, w_n) - (L - 1), 3);
        check("cont_d_rdata", w_rdat[L],         64'h0060_005F_005E_005D);
        check("cont_i_rdata", w_rdat[2 * L + 2], 64'h0050_004F_004E_004D);

        // Sustained contention: four grants
        keep_alive = 1'b1; i_read = 1'b1; d_read = 1'b1;
        watch(4 * (L + 2) + 2, -1);
        ns = 0;
        for (int k = 0; k < w_n; k++) begin
            if ((w_id[k] || w_dd[k]) && ns < 4) begin
                seq[ns] = w_dd[k] ? 1 : 0;
                ns++;
            end
        end
        check_int("sust_done_count", ns, 4);
`ifdef MEM_ARB_RR_EN
        check_int("sust_0", seq[0], 1); check_int("sust_1", seq[1], 0);
        check_int("sust_2", seq[2], 1); check_int("sust_3", seq[3], 0);
`else
        check_int("sust_0", seq[0], 1); check_int("sust_1", seq[1], 1);
        check_int("sust_2", seq[2], 1); check_int("sust_3", seq[3], 1);
`endif
        keep_alive = 1'b0; i_read = 1'b0; d_read = 1'b0;
        repeat (L + 4) tick();

        // D read+write together: write first, frozen address, drop mid-BUSY, then the read
        d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        watch(2 * (L + 2) + 4, 2);
        check_int("both_write_cycles", count1(w_wr, w_n), L);
        check_int("both_write_first",  first1(w_wr, 0, w_n), 0);
        check("both_addr_frozen", 64'(w_ad[L - 1]), 64'h0200);
        check("both_wdata",       64'(w_wd[0]),     64'h1234);
        check_int("both_done1",   first1(w_dd, 0, w_n), L);
        check_int("both_read_start", first1(w_rd, 0, w_n), L + 2);
        check("both_read_addr", 64'(w_ad[L + 2]), 64'h0300);
        check_int("both_done2",   first1(w_dd, L + 1, w_n), 2 * L + 2);
        check_int("both_done_count", count1(w_dd, w_n), 2);
        check("both_read_rdata", w_rdat[2 * L + 2], 64'h0030_002F_002E_002D);

        // Reset during BUSY aborts asynchronously
        i_read = 1'b1; i_addr = 16'h0777;
        tick();
        #1;
        check("pre_reset_strobe", 64'(mem_read), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_mem_read", 64'(mem_read), 64'd0);
        check("async_mem_addr", 64'(mem_addr), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_hold_mem_read", 64'(mem_read), 64'd0);
            check("rst_hold_i_done",   64'(i_done),   64'd0);
        end
        i_read = 1'b0;
        tick();
        reset_n = 1'b1;
        watch(L + 4, -1);
        check_int("post_reset_no_done", count1(w_id, w_n), 0);
        check_int("post_reset_no_read", count1(w_rd, w_n), 0);

        // Randomised traffic checked by the per-cycle compare
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (!i_read && $urandom_range(3) == 0) begin
                i_read = 1'b1; i_addr = 16'($urandom);
            end
            if (!d_read && !d_write && $urandom_range(3) == 0) begin
                case ($urandom_range(2))
                    0:       d_read = 1'b1;
                    1:       d_write = 1'b1;
                    default: begin d_read = 1'b1; d_write = 1'b1; end
                endcase
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            if (m_busy && m_t < L) begin
                if ($urandom_range(4) == 0) begin
                    if (m_own == OWN_I) i_addr = 16'($urandom);
                    else begin d_addr = 16'($urandom); d_wdata = 16'($urandom); end
                end
                if ($urandom_range(7) == 0) begin
                    if (m_own == OWN_I)        i_read  = 1'b0;
                    else if (m_op == OP_WRITE) d_write = 1'b0;
                    else                       d_read  = 1'b0;
                end
            end
        end
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        repeat (L + 4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
